// File: rtl/fir_serial.sv
// -----------------------------------------------------------------------------
// fir_serial
//   Time-multiplexed FIR filter built around one multiply-accumulate unit.
//   A sample is accepted in IDLE, the MAC walks the TAPS taps one per clock,
//   and a final DONE cycle rounds, shifts and saturates the accumulator onto
//   out_data. One sample is processed every TAPS+2 clocks.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   in_data is offered
//   in_ready   block can accept a sample (high only in IDLE)
//   in_data    signed input sample, DATA_W bits
//   flush      clear the delay line (IDLE only, loses to in_valid)
//   coef_we    coefficient write strobe (IDLE only)
//   coef_addr  tap index to write; indices >= TAPS are ignored
//   coef_data  signed coefficient, COEF_W bits
//   out_valid  one-cycle pulse marking a new out_data
//   out_data   filtered sample, holds between pulses
//   sat_flag   out_data was clamped; aligned with out_valid
// -----------------------------------------------------------------------------
module fir_serial #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 16,
  parameter int FRAC   = 15,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              sat_flag
);

  localparam int KW     = (AW > 0) ? AW : 1;
  localparam int PW     = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;

  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

  // Half-LSB bias at the output scale; zero when no shift is applied.
  localparam logic signed [ACC_W:0] RND =
    (FRAC > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;

  // Output range limits sign-extended to the rounded-value width.
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W+1-DATA_W){1'b0}}, 1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W+1-DATA_W){1'b1}}, 1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [DATA_W-1:0] r_x [TAPS];
  logic signed [COEF_W-1:0] r_c [TAPS];
  logic signed [ACC_W-1:0]  r_acc;
  logic [KW-1:0]            r_k;

  logic                     r_out_valid;
  logic [DATA_W-1:0]        r_out_data;
  logic                     r_sat_flag;

  logic signed [DATA_W-1:0] w_in_data;
  logic signed [COEF_W-1:0] w_coef_data;
  logic                     w_addr_ok;
  logic signed [DATA_W-1:0] w_xk;
  logic signed [COEF_W-1:0] w_ck;
  logic signed [PW-1:0]     w_xk_ext;
  logic signed [PW-1:0]     w_ck_ext;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W:0]    w_rounded;
  logic [DATA_W:0]          w_sat_res;

  // Add the rounding bias and arithmetic-shift right: round half toward +inf.
  function automatic logic signed [ACC_W:0] round_shift(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W:0] t;
    t = (ACC_W+1)'(a) + RND;
    return t >>> FRAC;
  endfunction

  // Clamp to DATA_W signed range. Bit DATA_W of the result is the clamp flag.
  function automatic logic [DATA_W:0] saturate(
    input logic signed [ACC_W:0] r
  );
    if (r > SAT_MAX) begin
      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    end else if (r < SAT_MIN) begin
      return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, r[DATA_W-1:0]};
    end
  endfunction

  assign w_in_data   = in_data;
  assign w_coef_data = coef_data;
  assign w_addr_ok   = ({1'b0, coef_addr} < (AW+1)'(TAPS));

  assign w_xk        = r_x[r_k];
  assign w_ck        = r_c[r_k];
  assign w_xk_ext    = PW'(w_xk);
  assign w_ck_ext    = PW'(w_ck);
  assign w_prod      = w_xk_ext * w_ck_ext;
  assign w_prod_ext  = ACC_W'(w_prod);

  assign w_rounded   = round_shift(r_acc);
  assign w_sat_res   = saturate(w_rounded);

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign sat_flag    = r_sat_flag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        if (r_k == K_LAST) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_x[i] <= '0;
        r_c[i] <= '0;
      end
      r_acc       <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat_flag  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_sat_flag  <= 1'b0;
      case (r_state)
        // Accept stage: sample enters the delay line, coefficient bank updates.
        IDLE: begin
          if (coef_we && w_addr_ok) begin
            r_c[coef_addr] <= w_coef_data;
          end
          if (in_valid) begin
            r_x[0] <= w_in_data;
            for (int i = 1; i < TAPS; i++) begin
              r_x[i] <= r_x[i-1];
            end
            r_acc <= '0;
            r_k   <= '0;
          end else if (flush) begin
            for (int i = 0; i < TAPS; i++) begin
              r_x[i] <= '0;
            end
          end
        end
        // MAC stage: one tap per clock, full-precision product.
        MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_k   <= r_k + 1'b1;
        end
        // Output stage: round, shift, saturate and publish.
        DONE: begin
          r_out_data  <= w_sat_res[DATA_W-1:0];
          r_sat_flag  <= w_sat_res[DATA_W];
          r_out_valid <= 1'b1;
        end
        default: begin
          r_k <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial.sv
module tb_fir_serial;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        flush = 1'b0;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        sat_flag;

  int checks = 0;
  int errors = 0;

  fir_serial #(
    .DATA_W(16),
    .COEF_W(16),
    .TAPS  (16),
    .FRAC  (15)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (flush),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = 16'(val);
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Offer one sample, optionally with flush asserted alongside, optionally
  // pulsing coef_we(addr 0, data 0)+flush in the middle of the MAC pass.
  // lat counts edges after the accept edge until out_valid is seen.
  task automatic run_sample(input logic [15:0] d, input logic fl, input logic disturb,
                            output logic [15:0] od, output logic os, output int lat);
    logic got;
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      if (disturb && lat == 2) begin
        coef_we   = 1'b1;
        coef_addr = 4'd0;
        coef_data = 16'd0;
        flush     = 1'b1;
      end else begin
        coef_we = 1'b0;
        flush   = 1'b0;
      end
      tick();
      lat++;
      if (out_valid) got = 1'b1;
    end
    coef_we = 1'b0;
    flush   = 1'b0;
    od = out_data;
    os = sat_flag;
  endtask

  task automatic test_reset;
    logic [15:0] od;
    logic os;
    int lat;
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_during: got %b want 1", in_ready);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++; $display("FAIL reset_out_data: got %h want 0000", out_data);
    end
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag);
    end
    run_sample(16'd1000, 1'b0, 1'b0, od, os, lat);
    checks++;
    if (lat !== 17) begin
      errors++; $display("FAIL zero_coef_latency: got %0d want 17", lat);
    end
    checks++;
    if (od !== 16'h0000) begin
      errors++; $display("FAIL zero_coef_out: got %h want 0000", od);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL pulse_width: out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++; $display("FAIL out_data_hold: got %h want 0000", out_data);
    end
  endtask

  task automatic test_single_tap;
    logic [15:0] od;
    logic os;
    int lat;
    write_coef(0, 16384);
    run_sample(16'h4000, 1'b0, 1'b0, od, os, lat);
    checks++;
    if (lat !== 17) begin
      errors++; $display("FAIL single_tap_latency: got %0d want 17", lat);
    end
    checks++;
    if (od !== 16'h2000) begin
      errors++; $display("FAIL single_tap_out: got %h want 2000", od);
    end
    checks++;
    if (os !== 1'b0) begin
      errors++; $display("FAIL single_tap_sat: got %b want 0", os);
    end
  endtask

  task automatic test_impulse;
    logic [15:0] od;
    logic [15:0] exp_v;
    logic os;
    int lat;
    for (int k = 0; k < 16; k++) write_coef(k, 1024 * (k + 1));
    do_flush();
    for (int n = 0; n < 16; n++) begin
      run_sample((n == 0) ? 16'd32767 : 16'd0, 1'b0, 1'b0, od, os, lat);
      exp_v = 16'(1024 * (n + 1));
      checks++;
      if (od !== exp_v || lat !== 17) begin
        errors++;
        $display("FAIL impulse_%0d: got %0d (lat %0d) want %0d (lat 17)", n, od, lat, exp_v);
      end
      checks++;
      if (os !== 1'b0) begin
        errors++; $display("FAIL impulse_sat_%0d: got %b want 0", n, os);
      end
    end
  endtask

  task automatic test_saturation;
    logic [15:0] od;
    logic [15:0] exp_v;
    logic os;
    logic exp_s;
    int lat;
    for (int k = 0; k < 16; k++) write_coef(k, 32767);
    // Positive: first output 32767*32767/32768 rounds to 32766, then clamps.
    do_flush();
    for (int n = 0; n < 16; n++) begin
      run_sample(16'd32767, 1'b0, 1'b0, od, os, lat);
      exp_v = (n == 0) ? 16'd32766 : 16'd32767;
      exp_s = (n == 0) ? 1'b0 : 1'b1;
      checks++;
      if (od !== exp_v || os !== exp_s) begin
        errors++;
        $display("FAIL sat_pos_%0d: got %0d sat %b want %0d sat %b", n, od, os, exp_v, exp_s);
      end
    end
    // Negative: first output is exactly -32767, then clamps to -32768.
    do_flush();
    for (int n = 0; n < 16; n++) begin
      run_sample(16'h8000, 1'b0, 1'b0, od, os, lat);
      exp_v = (n == 0) ? 16'h8001 : 16'h8000;
      exp_s = (n == 0) ? 1'b0 : 1'b1;
      checks++;
      if (od !== exp_v || os !== exp_s) begin
        errors++;
        $display("FAIL sat_neg_%0d: got %h sat %b want %h sat %b", n, od, os, exp_v, exp_s);
      end
    end
  endtask

  task automatic test_back_to_back;
    int accepts[$];
    int cyc;
    in_valid = 1'b1;
    in_data  = 16'd0;
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) accepts.push_back(cyc);
      if (out_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL ready_with_valid: in_ready got %b want 1", in_ready);
        end
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    repeat (20) tick();
    checks++;
    if (accepts.size() !== 4) begin
      errors++; $display("FAIL accept_count: got %0d want 4", accepts.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (accepts[i] - accepts[i-1] !== 18) begin
          errors++;
          $display("FAIL accept_spacing_%0d: got %0d want 18", i, accepts[i] - accepts[i-1]);
        end
      end
    end
  endtask

  task automatic test_ignore;
    logic [15:0] od;
    logic os;
    int lat;
    write_coef(0, 16384);
    write_coef(1, 8192);
    for (int k = 2; k < 16; k++) write_coef(k, 0);
    do_flush();
    // coef_we/flush pulsed mid-MAC must have no effect.
    run_sample(16'h4000, 1'b0, 1'b1, od, os, lat);
    checks++;
    if (od !== 16'h2000) begin
      errors++; $display("FAIL ignore_pass1: got %h want 2000", od);
    end
    run_sample(16'h0000, 1'b0, 1'b0, od, os, lat);
    checks++;
    if (od !== 16'h1000) begin
      errors++; $display("FAIL mac_flush_ignored: got %h want 1000", od);
    end
    run_sample(16'h4000, 1'b0, 1'b0, od, os, lat);
    checks++;
    if (od !== 16'h2000) begin
      errors++; $display("FAIL mac_coef_we_ignored: got %h want 2000", od);
    end
    // flush together with in_valid: sample accepted, history kept.
    run_sample(16'h0000, 1'b1, 1'b0, od, os, lat);
    checks++;
    if (od !== 16'h1000 || lat !== 17) begin
      errors++; $display("FAIL flush_with_valid: got %h (lat %0d) want 1000 (lat 17)", od, lat);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] od;
    logic os;
    int lat;
    int pulses;
    in_valid = 1'b1;
    in_data  = 16'h4000;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready);
    end
    tick();
    tick();
    reset_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      tick();
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL midreset_pulses: got %0d want 0", pulses);
    end
    write_coef(0, 16384);
    write_coef(1, 8192);
    run_sample(16'h4000, 1'b0, 1'b0, od, os, lat);
    checks++;
    if (od !== 16'h2000 || lat !== 17) begin
      errors++; $display("FAIL midreset_history: got %h (lat %0d) want 2000 (lat 17)", od, lat);
    end
  endtask

  initial begin
    test_reset();
    test_single_tap();
    test_impulse();
    test_saturation();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
